fault_mem_cfg: RTL and testbench
================================

Name: fault_mem_cfg

Overview:
- Parametrised, runtime-programmable fault-injecting single-port memory model; the target array the MBIST controller exercises during March-test regression.
- Successor to the fixed single-fault memory: one fault instance at a time, with address, bit and fault type loaded through a config port.
- Supports a one-shot mode and reports each activation on a pulse output, so benches can correlate MBIST fail flags with injected faults.

Parameters:
DATA_WIDTH, 8, word width in bits
ADDR_WIDTH, 6, address width
CAPACITY, 64, number of words; must be <= 2**ADDR_WIDTH
BIT_W, 3, width of the bit-select field; 2**BIT_W >= DATA_WIDTH

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous, active-low reset
write_read  input  1  1 = write, 0 = read; sampled every cycle
address  input  ADDR_WIDTH  word address
wdata  input  DATA_WIDTH  write data
rdata  output  DATA_WIDTH  registered read data
cfg_en  input  1  load fault configuration this edge
cfg_type  input  3  0 none, 1 SA0, 2 SA1, 3 TF-up, 4 TF-down, 5 CF-inv, 6 AF, 7 treated as none
cfg_addr  input  ADDR_WIDTH  faulty (aggressor) address
cfg_bit  input  BIT_W  faulty bit index
cfg_once  input  1  1 = fault fires once, then disarms
fault_hit  output  1  one-cycle pulse when the fault modifies an operation

Behaviour:
- Reset (rst_n low, async): rdata=0, fault_hit=0, stage-1 registers cleared (no op), config = none, FSM = DISARMED. Array contents are not reset.
- Pipeline:
  - Edge E0: stage 1 registers write_read, address, wdata.
  - Edge E1: array write or read into rd_q; fault logic evaluated; fault_hit registered.
  - Edge E2: rdata <= rd_q.
  - Read latency: 2 edges. rdata holds its value between reads.
- Write at E0 followed by a read of the same address at E0+1 returns the new data; no hazard.
- Out-of-range address (>= CAPACITY): write dropped, read returns 0, no fault activation.
- Config:
  - cfg_en sampled at an edge loads all cfg_* fields.
  - FSM goes to ARMED, or DISARMED if cfg_type is 0 or 7.
  - An op in stage 2 on the same edge uses the old config.
  - cfg_addr >= CAPACITY or cfg_bit >= DATA_WIDTH: the fault never activates.
- FSM states:
  - DISARMED: no faults.
  - ARMED: fault applied.
  - FIRED: entered from ARMED on the first activation when cfg_once=1; behaves as DISARMED.
  - ARMED is re-entered only via cfg_en.
- Fault semantics (ARMED only; A = cfg_addr, b = cfg_bit, V = (A+1) mod CAPACITY):
  - SA0/SA1: write to A stores bit b forced to 0/1; a read of A returns bit b forced. Activation when the forced value differs from the written or stored value.
  - TF-up: write to A with old bit b = 0 and new bit b = 1 leaves bit b = 0; other bits written normally. Activation on that case.
  - TF-down: symmetric for a 1->0 transition.
  - CF-inv: write to A whose bit b changes value stores A normally and inverts V[b] on the same edge. Activation on that case.
  - AF: every write to A is stored at V instead; A is unchanged; reads are unaffected. Every such write is an activation.
- fault_hit is high for exactly the cycle after the E1 edge of the activating op.
- Reset mid-operation discards in-flight ops; a later cfg_en is required to re-arm.

Optional Feature:
- Macro: FAULT_MEM_CNT_EN.
- Defined: adds output fault_cnt [15:0].
  - Increments on each fault_hit and saturates at 16'hFFFF.
  - Cleared by reset and by cfg_en.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, cfg none, write 8'hA5 to addr 3, read addr 3 -> rdata=8'hA5 two edges after the read is sampled; fault_hit stays 0.
- cfg SA1, A=5, b=0; write 8'h00 to 5; read 5 -> rdata=8'h01, fault_hit pulses once on the write.
- cfg TF-up, A=7, b=2; write 8'h00 then 8'hFF to 7; read -> 8'hFB, one fault_hit.
- cfg CF-inv, A=63, b=1, CAPACITY=64; write 8'h00 to 0, 8'h00 to 63, then 8'h02 to 63; read 0 -> 8'h02 (wrap to victim 0).
- cfg AF, A=10, cfg_once=1; write 8'h11 to 10, then 8'h22 to 10 -> addr 11 = 8'h11, addr 10 = 8'h22, exactly one fault_hit.
- FAULT_MEM_CNT_EN defined, cfg SA0 at A=2, b=7; write 8'h80 to 2 three times -> fault_cnt=3; assert cfg_en -> fault_cnt=0.

Source files
------------

// File: rtl/fault_mem_cfg.sv
// Runtime-programmable fault-injecting single-port memory: one configurable fault
// (stuck-at, transition, coupling, address) with optional one-shot; FAULT_MEM_CNT_EN adds fault_cnt.
module fault_mem_cfg #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int CAPACITY   = 64,
  parameter int BIT_W      = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  write_read,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic                  cfg_en,
  input  logic [2:0]            cfg_type,
  input  logic [ADDR_WIDTH-1:0] cfg_addr,
  input  logic [BIT_W-1:0]      cfg_bit,
  input  logic                  cfg_once,
  output logic                  fault_hit
`ifdef FAULT_MEM_CNT_EN
  ,
  output logic [15:0]           fault_cnt
`endif
);

  localparam logic [2:0] T_SA0 = 3'd1;
  localparam logic [2:0] T_SA1 = 3'd2;
  localparam logic [2:0] T_TFU = 3'd3;
  localparam logic [2:0] T_TFD = 3'd4;
  localparam logic [2:0] T_CF  = 3'd5;
  localparam logic [2:0] T_AF  = 3'd6;

  localparam logic [ADDR_WIDTH:0]   CAP_EXT = (ADDR_WIDTH+1)'(CAPACITY);
  localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(CAPACITY - 1);
  localparam logic [BIT_W:0]        DW_EXT  = (BIT_W+1)'(DATA_WIDTH);

  typedef enum logic [1:0] {ST_DISARMED, ST_ARMED, ST_FIRED} state_t;

  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] mem [CAPACITY];

  logic                  s1_valid, s1_write;
  logic [ADDR_WIDTH-1:0] s1_addr;
  logic [DATA_WIDTH-1:0] s1_wdata;

  logic [2:0]            cfg_type_q;
  logic [ADDR_WIDTH-1:0] cfg_addr_q;
  logic [BIT_W-1:0]      cfg_bit_q;
  logic                  cfg_once_q;

  logic [DATA_WIDTH-1:0] rd_q;
  logic                  rd_valid;

  logic                  in_range, cfg_ok, match, hit, sa_val;
  logic                  wr_en, vic_en;
  logic [ADDR_WIDTH-1:0] wr_addr, victim;
  logic [DATA_WIDTH-1:0] old_word, wr_word, rd_word, victim_word, vic_word;

  // Stage-2 datapath: the op in stage 1 meets the array and the current fault config.
  always_comb begin
    in_range    = {1'b0, s1_addr} < CAP_EXT;
    cfg_ok      = ({1'b0, cfg_addr_q} < CAP_EXT) && ({1'b0, cfg_bit_q} < DW_EXT);
    victim      = (cfg_addr_q == LAST) ? '0 : cfg_addr_q + 1'b1;
    old_word    = in_range ? mem[s1_addr] : '0;
    victim_word = mem[victim];
    match       = (state == ST_ARMED) && cfg_ok && s1_valid && in_range &&
                  (s1_addr == cfg_addr_q);
    sa_val      = (cfg_type_q == T_SA1);
    wr_en       = s1_valid && s1_write && in_range;
    wr_addr     = s1_addr;
    wr_word     = s1_wdata;
    rd_word     = old_word;
    vic_en      = 1'b0;
    vic_word    = victim_word;
    vic_word[cfg_bit_q] = ~victim_word[cfg_bit_q];
    hit         = 1'b0;
    if (match) begin
      case (cfg_type_q)
        T_SA0, T_SA1: begin
          if (s1_write) begin
            hit = (s1_wdata[cfg_bit_q] != sa_val);
            wr_word[cfg_bit_q] = sa_val;
          end else begin
            hit = (old_word[cfg_bit_q] != sa_val);
            rd_word[cfg_bit_q] = sa_val;
          end
        end
        T_TFU: begin
          if (s1_write && !old_word[cfg_bit_q] && s1_wdata[cfg_bit_q]) begin
            wr_word[cfg_bit_q] = 1'b0;
            hit = 1'b1;
          end
        end
        T_TFD: begin
          if (s1_write && old_word[cfg_bit_q] && !s1_wdata[cfg_bit_q]) begin
            wr_word[cfg_bit_q] = 1'b1;
            hit = 1'b1;
          end
        end
        T_CF: begin
          if (s1_write && (old_word[cfg_bit_q] != s1_wdata[cfg_bit_q])) begin
            vic_en = 1'b1;
            hit    = 1'b1;
          end
        end
        T_AF: begin
          if (s1_write) begin
            wr_addr = victim;
            hit     = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // A new config always wins over a same-edge one-shot disarm.
  always_comb begin
    state_nxt = state;
    if (cfg_en) begin
      state_nxt = (cfg_type == 3'd0 || cfg_type == 3'd7) ? ST_DISARMED : ST_ARMED;
    end else if (state == ST_ARMED && hit && cfg_once_q) begin
      state_nxt = ST_FIRED;
    end
  end

  // Array contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en)  mem[wr_addr] <= wr_word;
    if (vic_en) mem[victim]  <= vic_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_write   <= 1'b0;
      s1_addr    <= '0;
      s1_wdata   <= '0;
      cfg_type_q <= '0;
      cfg_addr_q <= '0;
      cfg_bit_q  <= '0;
      cfg_once_q <= 1'b0;
      rd_q       <= '0;
      rd_valid   <= 1'b0;
      rdata      <= '0;
      fault_hit  <= 1'b0;
      state      <= ST_DISARMED;
    end else begin
      s1_valid  <= 1'b1;
      s1_write  <= write_read;
      s1_addr   <= address;
      s1_wdata  <= wdata;
      rd_valid  <= s1_valid && !s1_write;
      if (s1_valid && !s1_write) rd_q <= rd_word;
      if (rd_valid) rdata <= rd_q;
      fault_hit <= hit;
      state     <= state_nxt;
      if (cfg_en) begin
        cfg_type_q <= cfg_type;
        cfg_addr_q <= cfg_addr;
        cfg_bit_q  <= cfg_bit;
        cfg_once_q <= cfg_once;
      end
    end
  end

`ifdef FAULT_MEM_CNT_EN
  // Counts activations as they are registered, so it moves together with fault_hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_cnt <= '0;
    end else if (cfg_en) begin
      fault_cnt <= '0;
    end else if (hit && fault_cnt != 16'hFFFF) begin
      fault_cnt <= fault_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fault_mem_cfg.sv
// Bench for fault_mem_cfg: directed fault scenarios plus random ops, configs and resets,
// all checked every cycle against a transaction-level memory/fault model.
module tb_fault_mem_cfg;

  localparam int CAP = 48;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       write_read = 1'b0;
  logic [5:0] address = '0;
  logic [7:0] wdata = '0;
  logic [7:0] rdata;
  logic       cfg_en = 1'b0;
  logic [2:0] cfg_type = '0;
  logic [5:0] cfg_addr = '0;
  logic [3:0] cfg_bit = '0;
  logic       cfg_once = 1'b0;
  logic       fault_hit;
`ifdef FAULT_MEM_CNT_EN
  logic [15:0] fault_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;
  int hits_seen = 0;

  fault_mem_cfg #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .CAPACITY(CAP), .BIT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .write_read(write_read), .address(address),
    .wdata(wdata), .rdata(rdata), .cfg_en(cfg_en), .cfg_type(cfg_type),
    .cfg_addr(cfg_addr), .cfg_bit(cfg_bit), .cfg_once(cfg_once),
    .fault_hit(fault_hit)
`ifdef FAULT_MEM_CNT_EN
    , .fault_cnt(fault_cnt)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0] mm [CAP];
  logic [7:0] exp_q[$];
  logic [7:0] exp_rdata;
  logic       exp_hit;
  logic [15:0] exp_cnt;
  int  m_type, m_addr, m_bit;
  bit  m_once, m_armed;
  bit  p_valid, p_wr;
  int  p_addr;
  logic [7:0] p_wdata;

  task automatic model_reset();
    exp_q.delete();
    exp_rdata = 8'h00;
    exp_hit = 1'b0;
    exp_cnt = 16'h0;
    m_type = 0; m_addr = 0; m_bit = 0; m_once = 0; m_armed = 0;
    p_valid = 0;
  endtask

  task automatic model_exec();
    int a, b, v;
    bit inr, act, hit, frc;
    logic [7:0] old, nw, val;
    a = p_addr;
    b = m_bit;
    inr = (a < CAP);
    v = (m_addr + 1) % CAP;
    act = m_armed && (m_addr < CAP) && (m_bit < 8) && inr && (a == m_addr);
    frc = (m_type == 2);
    hit = 0;
    if (p_wr) begin
      if (inr) begin
        old = mm[a];
        nw = p_wdata;
        if (act) begin
          case (m_type)
            1, 2: if (nw[b] != frc) begin nw[b] = frc; hit = 1; end
            3: if (old[b] == 1'b0 && nw[b] == 1'b1) begin nw[b] = 1'b0; hit = 1; end
            4: if (old[b] == 1'b1 && nw[b] == 1'b0) begin nw[b] = 1'b1; hit = 1; end
            5: if (old[b] != nw[b]) hit = 1;
            6: hit = 1;
            default: ;
          endcase
        end
        if (act && m_type == 6) mm[v] = nw;
        else mm[a] = nw;
        if (hit && m_type == 5) mm[v][b] = ~mm[v][b];
      end
    end else begin
      val = inr ? mm[a] : 8'h00;
      if (act && (m_type == 1 || m_type == 2)) begin
        if (val[b] != frc) hit = 1;
        val[b] = frc;
      end
      exp_q.push_back(val);
    end
    if (hit && m_once) m_armed = 0;
    exp_hit = hit;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        if (exp_q.size() > 0) exp_rdata = exp_q.pop_front();
        exp_hit = 1'b0;
        if (p_valid) model_exec();
        if (cfg_en) begin
          m_type = int'(cfg_type); m_addr = int'(cfg_addr);
          m_bit = int'(cfg_bit); m_once = cfg_once;
          m_armed = !(cfg_type == 3'd0 || cfg_type == 3'd7);
          exp_cnt = 16'h0;
        end else if (exp_hit && exp_cnt != 16'hFFFF) begin
          exp_cnt = exp_cnt + 16'd1;
        end
        p_valid = 1; p_wr = write_read; p_addr = int'(address); p_wdata = wdata;
      end
    end
  end

  // ---------------- compare process ----------------
  initial begin
    forever begin
      @(negedge clk);
      vectors++;
      if (rdata !== exp_rdata) begin
        miscompares++;
        $display("FAIL rdata t=%0t got=%h exp=%h", $time, rdata, exp_rdata);
      end
      vectors++;
      if (fault_hit !== exp_hit) begin
        miscompares++;
        $display("FAIL fault_hit t=%0t got=%b exp=%b", $time, fault_hit, exp_hit);
      end
`ifdef FAULT_MEM_CNT_EN
      vectors++;
      if (fault_cnt !== exp_cnt) begin
        miscompares++;
        $display("FAIL fault_cnt t=%0t got=%0d exp=%0d", $time, fault_cnt, exp_cnt);
      end
`endif
      if (fault_hit === 1'b1) hits_seen++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic op(input logic wr, input logic [5:0] a, input logic [7:0] d);
    write_read = wr; address = a; wdata = d; cfg_en = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic cfg(input logic [2:0] t, input logic [5:0] a, input logic [3:0] b,
                     input logic once);
    cfg_type = t; cfg_addr = a; cfg_bit = b; cfg_once = once;
    write_read = 1'b0; address = '0; wdata = '0; cfg_en = 1'b1;
    @(negedge clk); #1;
    cfg_en = 1'b0;
  endtask

  task automatic read_expect(input string name, input logic [5:0] a, input logic [7:0] e);
    op(1'b0, a, 8'h00);
    op(1'b0, a, 8'h00);
    op(1'b0, a, 8'h00);
    check(name, {8'h00, rdata}, {8'h00, e});
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    op(1'b0, 6'd0, 8'h00);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int h0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_rdata", {8'h00, rdata}, 16'h0000);
    check("reset_hit", {15'h0, fault_hit}, 16'h0000);
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) op(1'b1, 6'(i), 8'h00);

    h0 = hits_seen;
    op(1'b1, 6'd3, 8'hA5);
    read_expect("none_rd3", 6'd3, 8'hA5);
    check("none_hits", 16'(hits_seen - h0), 16'd0);

    cfg(3'd2, 6'd5, 4'd0, 1'b0);
    h0 = hits_seen;
    op(1'b1, 6'd5, 8'h00);
    read_expect("sa1_rd5", 6'd5, 8'h01);
    check("sa1_hits", 16'(hits_seen - h0), 16'd1);

    cfg(3'd3, 6'd7, 4'd2, 1'b0);
    h0 = hits_seen;
    op(1'b1, 6'd7, 8'h00);
    op(1'b1, 6'd7, 8'hFF);
    read_expect("tfu_rd7", 6'd7, 8'hFB);
    check("tfu_hits", 16'(hits_seen - h0), 16'd1);

    cfg(3'd5, 6'(CAP - 1), 4'd1, 1'b0);
    h0 = hits_seen;
    op(1'b1, 6'd0, 8'h00);
    op(1'b1, 6'(CAP - 1), 8'h00);
    op(1'b1, 6'(CAP - 1), 8'h02);
    read_expect("cf_victim0", 6'd0, 8'h02);
    read_expect("cf_aggr", 6'(CAP - 1), 8'h02);
    check("cf_hits", 16'(hits_seen - h0), 16'd1);

    cfg(3'd6, 6'd10, 4'd0, 1'b1);
    h0 = hits_seen;
    op(1'b1, 6'd10, 8'h11);
    op(1'b1, 6'd10, 8'h22);
    read_expect("af_rd11", 6'd11, 8'h11);
    read_expect("af_rd10", 6'd10, 8'h22);
    check("af_hits", 16'(hits_seen - h0), 16'd1);

    cfg(3'd0, 6'd0, 4'd0, 1'b0);
    op(1'b1, 6'd50, 8'h5A);
    read_expect("oor_rd50", 6'd50, 8'h00);
    cfg(3'd2, 6'd50, 4'd0, 1'b0);
    h0 = hits_seen;
    op(1'b1, 6'd50, 8'h00);
    read_expect("oor_cfg_rd", 6'd50, 8'h00);
    cfg(3'd2, 6'd5, 4'd9, 1'b0);
    op(1'b1, 6'd5, 8'h00);
    read_expect("oor_bit_rd5", 6'd5, 8'h00);
    check("oor_hits", 16'(hits_seen - h0), 16'd0);

    cfg(3'd2, 6'd5, 4'd0, 1'b0);
    reset_pulse();
    h0 = hits_seen;
    op(1'b1, 6'd5, 8'h00);
    read_expect("rst_disarm_rd5", 6'd5, 8'h00);
    check("rst_disarm_hits", 16'(hits_seen - h0), 16'd0);

`ifdef FAULT_MEM_CNT_EN
    cfg(3'd1, 6'd2, 4'd7, 1'b0);
    repeat (3) op(1'b1, 6'd2, 8'h80);
    op(1'b0, 6'd2, 8'h00);
    check("cnt_three", fault_cnt, 16'd3);
    cfg(3'd0, 6'd0, 4'd0, 1'b0);
    check("cnt_clear", fault_cnt, 16'd0);
`endif

    for (int n = 0; n < 3000; n++) begin
      int r;
      logic [5:0] a;
      r = $urandom_range(0, 99);
      if (r < 4) begin
        cfg(3'($urandom_range(0, 7)), 6'($urandom_range(0, 63)),
            4'($urandom_range(0, 9)), 1'($urandom_range(0, 1)));
      end else if (r == 4) begin
        reset_pulse();
      end else begin
        case ($urandom_range(0, 3))
          0, 1: a = cfg_addr;
          2: a = 6'($urandom_range(0, 3));
          default: a = 6'($urandom_range(0, 63));
        endcase
        op(1'($urandom_range(0, 1)), a, 8'($urandom));
      end
    end

    repeat (3) op(1'b0, 6'd0, 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
